line_fill_arbiter: RTL and testbench
====================================

// Module: line_fill_arbiter
// PURPOSE
//  Shares the single cacheline adaptor between the instruction cache and the data cache.
//  Accepts 256-bit line read/write requests from both caches and grants one at a time.
//  Priority is data-first, with a starvation limit so instruction fetch always progresses.
//  Latches the winning request and drives the adaptor until it responds.
//  Returns the response and line data to the winner only.
// PARAMETERS
//  LINE_W      256  cacheline width in bits
//  ADDR_W      32   address width in bits
//  STARVE_MAX  4    max consecutive data grants while inst waits; then inst is forced; >=1
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  rst          in   1       asynchronous, active-high reset
//  inst_read_i  in   1       icache line read request; held until inst_resp_o
//  inst_addr_i  in   ADDR_W  icache line address
//  inst_rdata_o out  LINE_W  line returned to icache; valid while inst_resp_o=1
//  inst_resp_o  out  1       one-cycle completion pulse to icache
//  data_read_i  in   1       dcache line read request; held until data_resp_o
//  data_write_i in   1       dcache writeback request; held until data_resp_o
//  data_addr_i  in   ADDR_W  dcache line address
//  data_wdata_i in   LINE_W  dcache writeback line
//  data_rdata_o out  LINE_W  line returned to dcache; valid while data_resp_o=1
//  data_resp_o  out  1       one-cycle completion pulse to dcache
//  mem_read_o   out  1       read request to adaptor; registered
//  mem_write_o  out  1       write request to adaptor; registered
//  mem_addr_o   out  ADDR_W  latched address to adaptor
//  mem_wdata_o  out  LINE_W  latched writeback line to adaptor
//  mem_rdata_i  in   LINE_W  line from adaptor; valid when mem_resp_i=1
//  mem_resp_i   in   1       adaptor completion, one cycle
// BEHAVIOUR
//  Reset:
//   - All outputs go to 0 and the FSM goes to IDLE.
//   - starve_cnt goes to 0.
//   - An in-flight transaction is abandoned; no resp is issued for it.
//  States: IDLE -> BUSY_I or BUSY_D -> RESP -> IDLE.
//  IDLE, arbitration in the cycle a request is seen:
//   - Data is requested when data_read_i or data_write_i is 1.
//   - Data only: grant D.
//   - Inst only: grant I.
//   - Both: grant D, unless starve_cnt == STARVE_MAX, in which case grant I.
//   - Neither: stay in IDLE.
//  Grant, effective at the next edge:
//   - Latch addr, wdata and op into mem_addr_o / mem_wdata_o / mem_read_o / mem_write_o.
//   - mem_* therefore rises exactly 1 cycle after the request is first seen in IDLE.
//   - data_read_i and data_write_i both 1 (illegal): treated as write.
//  BUSY_x:
//   - mem_* outputs are held constant until mem_resp_i=1.
//   - Requester input changes or drops are ignored because the request is latched.
//  On mem_resp_i=1 in BUSY_x:
//   - Clear mem_read_o / mem_write_o.
//   - Capture mem_rdata_i into x_rdata_o.
//   - Go to RESP.
//  RESP (exactly 1 cycle):
//   - x_resp_o=1 and x_rdata_o is valid; the other resp stays 0.
//   - Requests are NOT sampled, so the winner's request, which is still high, is not re-granted.
//   - Next state is IDLE.
//  Latency: grant to resp = adaptor latency + 2 cycles.
//  Minimum spacing between back-to-back grants: 1 IDLE cycle.
//  x_rdata_o holds its last captured value outside RESP.
//  starve_cnt, updated at grant only:
//   - D granted while inst_read_i=1: increment, saturating at STARVE_MAX.
//   - I granted, or D granted with inst_read_i=0: clear to 0.
//  mem_resp_i in IDLE or RESP is ignored.
//  Writes return a resp pulse; data_rdata_o is also updated from mem_rdata_i (don't-care).
// TESTING
//  - Inst only: inst_read_i=1, addr=0x0000_0060, adaptor resp after 4 cycles with line L
//    -> mem_read_o rises 1 cycle later with addr 0x60; inst_resp_o pulses 1 cycle with
//    inst_rdata_o=L; no second grant.
//  - Simultaneous inst read @0x100 and data write @0x200
//    -> data write served first (mem_write_o, mem_wdata_o=data line); inst read served next;
//    one IDLE cycle between the two grants.
//  - Starvation, STARVE_MAX=4: inst and data requests held continuously
//    -> grant order D,D,D,D,I,D...
//  - Requester drops its request and changes data_addr_i mid-BUSY
//    -> mem_addr_o stays at the latched value; data_resp_o still pulses once.
//  - Reset asserted during BUSY_D
//    -> all outputs 0 immediately (async); after release, no stale resp; a new request is
//    granted normally.
//  - mem_resp_i asserted spuriously in IDLE
//    -> no resp output and no state change.

Source files
------------

// File: rtl/line_fill_arbiter.sv
// Arbitrates the single cacheline adaptor between icache and dcache.
// Data-first priority with a starvation limit that guarantees instruction fetch progress.
module line_fill_arbiter #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [LINE_W-1:0] inst_rdata_o,
  output logic              inst_resp_o,
  input  logic              data_read_i,
  input  logic              data_write_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [LINE_W-1:0] data_wdata_i,
  output logic [LINE_W-1:0] data_rdata_o,
  output logic              data_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             owner_d, owner_d_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             mem_read_nxt, mem_write_nxt;
  logic             data_req, grant_i, grant_d;
  logic             capture_i, capture_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      starve_cnt  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner_d     <= owner_d_nxt;
      starve_cnt  <= starve_cnt_nxt;
      mem_read_o  <= mem_read_nxt;
      mem_write_o <= mem_write_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_d_nxt    = owner_d;
    starve_cnt_nxt = starve_cnt;
    mem_read_nxt   = mem_read_o;
    mem_write_nxt  = mem_write_o;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    data_req       = data_read_i | data_write_i;

    case (state)
      IDLE: begin
        // Data wins unless instruction fetch has already been passed over STARVE_MAX times.
        if (data_req && !(inst_read_i && (starve_cnt == CNT_MAX))) begin
          grant_d = 1'b1;
        end else if (inst_read_i) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_nxt     = BUSY_D;
          owner_d_nxt   = 1'b1;
          mem_write_nxt = data_write_i;
          mem_read_nxt  = ~data_write_i;
          if (!inst_read_i) begin
            starve_cnt_nxt = '0;
          end else if (starve_cnt != CNT_MAX) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end else if (grant_i) begin
          state_nxt      = BUSY_I;
          owner_d_nxt    = 1'b0;
          mem_read_nxt   = 1'b1;
          mem_write_nxt  = 1'b0;
          starve_cnt_nxt = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp_i) begin
          state_nxt     = RESP;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
        end
      end
      RESP: begin
        // Requests are not sampled here so the still-high winning request is not re-granted.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign capture_i = (state == BUSY_I) && mem_resp_i;
  assign capture_d = (state == BUSY_D) && mem_resp_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      inst_rdata_o <= '0;
      data_rdata_o <= '0;
    end else begin
      if (grant_d) begin
        mem_addr_o  <= data_addr_i;
        mem_wdata_o <= data_wdata_i;
      end else if (grant_i) begin
        mem_addr_o  <= inst_addr_i;
      end
      if (capture_i) begin
        inst_rdata_o <= mem_rdata_i;
      end
      if (capture_d) begin
        data_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign inst_resp_o = (state == RESP) && !owner_d;
  assign data_resp_o = (state == RESP) && owner_d;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter: cycle table plus starvation, drop and reset sequences.
module tb_line_fill_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [LINE_W-1:0] L1 = {8{32'hA1A1_0001}};
  localparam logic [LINE_W-1:0] L2 = {8{32'hB2B2_0002}};
  localparam logic [LINE_W-1:0] L3 = {8{32'hC3C3_0003}};
  localparam logic [LINE_W-1:0] L4 = {8{32'hD4D4_0004}};
  localparam logic [LINE_W-1:0] WL = {8{32'hEEEE_5555}};

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_read_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [LINE_W-1:0] inst_rdata_o;
  logic              inst_resp_o;
  logic              data_read_i;
  logic              data_write_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [LINE_W-1:0] data_wdata_i;
  logic [LINE_W-1:0] data_rdata_o;
  logic              data_resp_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_resp_i;

  line_fill_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_read_i(inst_read_i), .inst_addr_i(inst_addr_i),
    .inst_rdata_o(inst_rdata_o), .inst_resp_o(inst_resp_o),
    .data_read_i(data_read_i), .data_write_i(data_write_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_resp_o(data_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ir;
    logic [ADDR_W-1:0] ia;
    logic              dr;
    logic              dw;
    logic [ADDR_W-1:0] da;
    logic              mr;
    logic [LINE_W-1:0] mrd;
    logic              e_mread;
    logic              e_mwrite;
    logic [ADDR_W-1:0] e_maddr;
    logic [LINE_W-1:0] e_mwd;
    logic              e_iresp;
    logic              e_dresp;
    logic [LINE_W-1:0] e_ird;
    logic [LINE_W-1:0] e_drd;
  } vec_t;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_read_i  = 1'b0;
    inst_addr_i  = '0;
    data_read_i  = 1'b0;
    data_write_i = 1'b0;
    data_addr_i  = '0;
    mem_resp_i   = 1'b0;
    mem_rdata_i  = '0;
  endtask

  function automatic vec_t mk(input logic ir, input logic [ADDR_W-1:0] ia, input logic dr,
                              input logic dw, input logic [ADDR_W-1:0] da, input logic mr,
                              input logic [LINE_W-1:0] mrd, input logic e_mread,
                              input logic e_mwrite, input logic [ADDR_W-1:0] e_maddr,
                              input logic [LINE_W-1:0] e_mwd, input logic e_iresp,
                              input logic e_dresp, input logic [LINE_W-1:0] e_ird,
                              input logic [LINE_W-1:0] e_drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.mr = mr; v.mrd = mrd;
    v.e_mread = e_mread; v.e_mwrite = e_mwrite; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
    v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_ird = e_ird; v.e_drd = e_drd;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    byte grants[6];
    int  ng;
    int  pulses;
    logic prev_busy;

    // Inst-only fill, simultaneous write+read, spurious adaptor response in IDLE.
    tbl[0]  = mk(1, 32'h60,  0, 0, 32'h0,   0, '0, 1, 0, 32'h60,  '0, 0, 0, '0, '0);
    tbl[1]  = mk(1, 32'h60,  0, 0, 32'h0,   0, '0, 1, 0, 32'h60,  '0, 0, 0, '0, '0);
    tbl[2]  = mk(1, 32'h60,  0, 0, 32'h0,   0, '0, 1, 0, 32'h60,  '0, 0, 0, '0, '0);
    tbl[3]  = mk(1, 32'h60,  0, 0, 32'h0,   1, L1, 0, 0, 32'h60,  '0, 1, 0, L1, '0);
    tbl[4]  = mk(1, 32'h60,  0, 0, 32'h0,   0, '0, 0, 0, 32'h60,  '0, 0, 0, L1, '0);
    tbl[5]  = mk(0, 32'h0,   0, 0, 32'h0,   0, '0, 0, 0, 32'h60,  '0, 0, 0, L1, '0);
    tbl[6]  = mk(1, 32'h100, 0, 1, 32'h200, 0, '0, 0, 1, 32'h200, WL, 0, 0, L1, '0);
    tbl[7]  = mk(1, 32'h100, 0, 1, 32'h200, 1, L2, 0, 0, 32'h200, WL, 0, 1, L1, L2);
    tbl[8]  = mk(1, 32'h100, 0, 0, 32'h200, 0, '0, 0, 0, 32'h200, WL, 0, 0, L1, L2);
    tbl[9]  = mk(1, 32'h100, 0, 0, 32'h0,   0, '0, 1, 0, 32'h100, WL, 0, 0, L1, L2);
    tbl[10] = mk(1, 32'h100, 0, 0, 32'h0,   1, L3, 0, 0, 32'h100, WL, 1, 0, L3, L2);
    tbl[11] = mk(0, 32'h0,   0, 0, 32'h0,   0, '0, 0, 0, 32'h100, WL, 0, 0, L3, L2);
    tbl[12] = mk(0, 32'h0,   0, 0, 32'h0,   1, L4, 0, 0, 32'h100, WL, 0, 0, L3, L2);
    tbl[13] = mk(0, 32'h0,   0, 0, 32'h0,   0, '0, 0, 0, 32'h100, WL, 0, 0, L3, L2);

    rst = 1'b1;
    idle_inputs();
    data_wdata_i = WL;
    #12;
    chk("rst_mem_read",  256'(mem_read_o), 256'(0));
    chk("rst_mem_write", 256'(mem_write_o), 256'(0));
    chk("rst_mem_addr",  256'(mem_addr_o), 256'(0));
    chk("rst_resp",      256'({inst_resp_o, data_resp_o}), 256'(0));
    chk("rst_rdata",     inst_rdata_o | data_rdata_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      inst_read_i  = tbl[i].ir;
      inst_addr_i  = tbl[i].ia;
      data_read_i  = tbl[i].dr;
      data_write_i = tbl[i].dw;
      data_addr_i  = tbl[i].da;
      mem_resp_i   = tbl[i].mr;
      mem_rdata_i  = tbl[i].mrd;
      step();
      chk($sformatf("r%0d_mem_read", i),   256'(mem_read_o),  256'(tbl[i].e_mread));
      chk($sformatf("r%0d_mem_write", i),  256'(mem_write_o), 256'(tbl[i].e_mwrite));
      chk($sformatf("r%0d_mem_addr", i),   256'(mem_addr_o),  256'(tbl[i].e_maddr));
      chk($sformatf("r%0d_mem_wdata", i),  mem_wdata_o,       tbl[i].e_mwd);
      chk($sformatf("r%0d_inst_resp", i),  256'(inst_resp_o), 256'(tbl[i].e_iresp));
      chk($sformatf("r%0d_data_resp", i),  256'(data_resp_o), 256'(tbl[i].e_dresp));
      chk($sformatf("r%0d_inst_rdata", i), inst_rdata_o,      tbl[i].e_ird);
      chk($sformatf("r%0d_data_rdata", i), data_rdata_o,      tbl[i].e_drd);
    end

    // Starvation: both requests held; adaptor answers the cycle after mem_* rises.
    idle_inputs();
    rst = 1'b1; #2; rst = 1'b0;
    inst_read_i = 1'b1; inst_addr_i = 32'h400;
    data_read_i = 1'b1; data_addr_i = 32'h300;
    ng = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 6; i++) grants[i] = "?";
    for (int c = 0; c < 100 && ng < 6; c++) begin
      step();
      if ((mem_read_o || mem_write_o) && !prev_busy) begin
        grants[ng] = (mem_addr_o == 32'h300) ? "D" : "I";
        ng++;
      end
      prev_busy  = mem_read_o || mem_write_o;
      mem_resp_i = mem_read_o || mem_write_o;
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("starve_grant%0d", i), 256'(grants[i]), 256'((i == 4) ? "I" : "D"));
    end

    // Dcache drops its request and moves its address while the read is outstanding.
    idle_inputs();
    rst = 1'b1; #2; rst = 1'b0;
    data_read_i = 1'b1; data_addr_i = 32'h500;
    step();
    chk("drop_grant", 256'(mem_read_o), 256'(1));
    data_read_i = 1'b0; data_addr_i = 32'h999;
    step(); step();
    chk("drop_addr_held", 256'(mem_addr_o), 256'(32'h500));
    chk("drop_read_held", 256'(mem_read_o), 256'(1));
    mem_resp_i = 1'b1; mem_rdata_i = L2;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      mem_resp_i = 1'b0;
      if (data_resp_o) pulses++;
    end
    chk("drop_resp_pulses", 256'(pulses), 256'(1));
    chk("drop_rdata", data_rdata_o, L2);

    // Asynchronous reset while a writeback is outstanding.
    idle_inputs();
    data_write_i = 1'b1; data_addr_i = 32'h600;
    step();
    chk("rb_write_up", 256'(mem_write_o), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("rb_async_write", 256'(mem_write_o), 256'(0));
    chk("rb_async_addr",  256'(mem_addr_o),  256'(0));
    chk("rb_async_wdata", mem_wdata_o, '0);
    chk("rb_async_rdata", data_rdata_o, '0);
    idle_inputs();
    step();
    rst = 1'b0;
    mem_resp_i = 1'b1; mem_rdata_i = L4;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_resp_i = 1'b0;
      if (inst_resp_o || data_resp_o) pulses++;
    end
    chk("rb_no_stale_resp", 256'(pulses), 256'(0));
    inst_read_i = 1'b1; inst_addr_i = 32'h700;
    step();
    chk("rb_new_read",  256'(mem_read_o), 256'(1));
    chk("rb_new_addr",  256'(mem_addr_o), 256'(32'h700));
    mem_resp_i = 1'b1; mem_rdata_i = L3;
    step();
    mem_resp_i = 1'b0;
    chk("rb_new_resp",  256'(inst_resp_o), 256'(1));
    chk("rb_new_rdata", inst_rdata_o, L3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
